alu_operand_buffer: RTL and testbench

// - Two-entry elastic buffer feeding ALU operands (A, B, ALU op) into the execute stage.
// - Upstream: register-read / operand-select logic. Downstream: 64-bit ALU and its bitwise AND/OR/XOR units.
// - Decouples the register read from an ALU that can stall, via valid/ready on both sides.
// - Full throughput of one operand set per cycle. Synchronous flush for branch squash.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/operand_slot.sv | 20 ++
 rtl/alu_operand_buffer.sv | 106 ++++++++++
 tb/tb_alu_operand_buffer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU operand path: operand bundle, ALU control encoding
// and the occupancy states of the operand buffer.
package alu_pkg;

  localparam int WIDTH = 64;
  localparam int OPW   = 3;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_XOR    = 3'b110
  } alu_op_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    alu_op_t     op;
  } alu_operands_t;

  // State value doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/operand_slot.sv
// One operand-set storage register with load enable.
module operand_slot
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  alu_operands_t d,
  output alu_operands_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '{a: '0, b: '0, op: ALU_PASS_B};
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_operand_buffer.sv
// Two-entry elastic buffer between operand select and the ALU; slot 0 is the
// head, slot 1 the tail. Outputs come straight from the slot 0 register.
//
// state | meaning
// EMPTY | no entries, out_valid low
// ONE   | head valid in slot 0
// FULL  | slot 0 head, slot 1 tail, in_ready low
module alu_operand_buffer
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [OPW-1:0]   out_op,
  output logic [1:0]       count
);

  occ_state_t    state_q, state_d;
  alu_operands_t in_set, slot0_d, slot0_q, slot1_q;
  logic          push, pop;
  logic          ld0, ld1, shift;

  assign in_set  = '{a: in_a, b: in_b, op: alu_op_t'(in_op)};
  assign push    = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign slot0_d = shift ? slot1_q : in_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = FULL;
          else if (pop && !push) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Flush suppresses all loads so a squashed push never reaches a slot.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    ld0       = 1'b0;
    ld1       = 1'b0;
    shift     = 1'b0;
    if (!flush) begin
      case (state_q)
        EMPTY: ld0 = push;
        ONE: begin
          ld0 = push & pop;
          ld1 = push & ~pop;
        end
        FULL: begin
          ld0   = pop;
          shift = pop;
        end
        default: ;
      endcase
    end
  end

  operand_slot u_slot0 (
    .clk   (clk),
    .reset (reset),
    .load  (ld0),
    .d     (slot0_d),
    .q     (slot0_q)
  );

  operand_slot u_slot1 (
    .clk   (clk),
    .reset (reset),
    .load  (ld1),
    .d     (in_set),
    .q     (slot1_q)
  );

  assign out_a  = slot0_q.a;
  assign out_b  = slot0_q.b;
  assign out_op = slot0_q.op;
  assign count  = state_q;

endmodule

// File: tb/tb_alu_operand_buffer.sv
// Scoreboard bench for alu_operand_buffer: accepted sets are queued at the
// handshake and compared in order when the ALU side consumes them.
module tb_alu_operand_buffer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [63:0] in_a, in_b, out_a, out_b;
  logic [2:0]  in_op, out_op;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  logic [130:0] sb[$];

  always #5 clk = ~clk;

  alu_operand_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [130:0] obs, input logic [130:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    chk("drain_empty", 131'(sb.size()), 131'd0);
  endtask

  // Monitor: pop/compare first, then record this cycle's accepted push.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", {out_a, out_b, out_op}, 131'd0);
        else chk("sb_data", {out_a, out_b, out_op}, sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back({in_a, in_b, in_op});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 64'hDEAD, 64'hBEEF, ALU_ADD);
    step(); step();
    chk("rst_count", 131'(count), 131'd0);
    chk("rst_out_valid", 131'(out_valid), 131'd0);
    chk("rst_in_ready", 131'(in_ready), 131'd1);
    chk("rst_data", {out_a, out_b, out_op}, {64'd0, 64'd0, ALU_PASS_B});

    // First push after reset, visible on the next cycle.
    reset = 1'b0;
    drive(1'b1, 64'h1, 64'h2, ALU_ADD);
    out_ready = 1'b1;
    step();
    drive(1'b0, 64'h0, 64'h0, ALU_PASS_B);
    chk("lat_valid", 131'(out_valid), 131'd1);
    chk("lat_data", {out_a, out_b, out_op}, {64'h1, 64'h2, ALU_ADD});
    step();
    chk("lat_drained", 131'(count), 131'd0);

    // Streaming: eight sets back to back with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'(i), ~64'(i), 3'(i % 8));
      chk("stream_in_ready", 131'(in_ready), 131'd1);
      step();
      chk("stream_count", 131'(count), 131'd1);
    end
    drive(1'b0, 64'h0, 64'h0, ALU_PASS_B);
    drain();
    chk("stream_end_count", 131'(count), 131'd0);

    // Backpressure: fill, hold off a third set, then release.
    out_ready = 1'b0;
    drive(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h11, ALU_AND);
    step();
    drive(1'b1, 64'h5555_5555_5555_5555, 64'h22, ALU_OR);
    step();
    chk("bp_count_full", 131'(count), 131'd2);
    chk("bp_in_ready", 131'(in_ready), 131'd0);
    drive(1'b1, 64'h7777, 64'h33, ALU_XOR);
    step();
    chk("bp_hold_count", 131'(count), 131'd2);
    chk("bp_head", 131'(out_a), 131'(64'hAAAA_AAAA_AAAA_AAAA));
    out_ready = 1'b1;
    step();
    chk("bp_after_pop", 131'(count), 131'd1);
    step();
    chk("bp_push_pop", 131'(count), 131'd1);
    chk("bp_third_head", 131'(out_a), 131'(64'h7777));
    drive(1'b0, 64'h0, 64'h0, ALU_PASS_B);
    drain();

    // Simultaneous push and pop at count 1.
    out_ready = 1'b0;
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h44, ALU_SUB);
    step();
    drive(1'b1, 64'h1010_1010_1010_1010, 64'h55, ALU_ADD);
    out_ready = 1'b1;
    step();
    chk("pp_count", 131'(count), 131'd1);
    chk("pp_head", 131'(out_a), 131'(64'h1010_1010_1010_1010));
    drive(1'b0, 64'h0, 64'h0, ALU_PASS_B);
    drain();

    // Flush while full, with a same-cycle push attempt.
    out_ready = 1'b0;
    drive(1'b1, 64'h8, 64'h66, ALU_ADD);
    step();
    drive(1'b1, 64'h9, 64'h77, ALU_SUB);
    step();
    chk("fl_full", 131'(count), 131'd2);
    drive(1'b1, 64'h3, 64'h88, ALU_XOR);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 64'h0, 64'h0, ALU_PASS_B);
    chk("fl_count", 131'(count), 131'd0);
    chk("fl_out_valid", 131'(out_valid), 131'd0);
    step(); step();
    chk("fl_stays_empty", 131'(out_valid), 131'd0);

    // Async reset between edges while full.
    out_ready = 1'b0;
    drive(1'b1, 64'hA1, 64'hB1, ALU_AND);
    step();
    drive(1'b1, 64'hA2, 64'hB2, ALU_OR);
    step();
    drive(1'b0, 64'h0, 64'h0, ALU_PASS_B);
    chk("ar_full", 131'(count), 131'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_count", 131'(count), 131'd0);
    chk("ar_out_valid", 131'(out_valid), 131'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 64'h42, 64'h24, ALU_SUB);
    step();
    drive(1'b0, 64'h0, 64'h0, ALU_PASS_B);
    chk("ar_post_data", {out_a, out_b, out_op}, {64'h42, 64'h24, ALU_SUB});
    drain();
    chk("ar_end_count", 131'(count), 131'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
